// File: rtl/grid_writer.sv
// grid_writer: sole writer to the fluid-state BRAM read by the pixel stage.
// After reset, or on init_start_in, sweeps every cell of the GRID_W x GRID_H
// grid (addr = x + GRID_W*y) writing a barrier border around a rest-pattern
// interior. Once initialised it accepts paint requests over valid/ready and
// writes a 3x3 brush of barrier cells (or erases them back to rest pattern).
//
// Ports:
//   pixel_clk_in     clock
//   rst_in           asynchronous active-low reset
//   init_start_in    one-cycle request to re-run initialisation (IDLE only)
//   paint_valid_in   paint request valid
//   paint_ready_out  paint request accepted when valid & ready
//   paint_x_in/y_in  brush centre coordinates (out-of-grid values are legal)
//   paint_erase_in   1 = write rest pattern, 0 = write barrier
//   we_out           BRAM write enable (registered)
//   addr_out         BRAM write address (registered)
//   data_out         BRAM write data, 9 direction bytes (registered)
//   busy_out         high while initialising or painting
//   init_done_out    high once an initialisation has completed
module grid_writer #(
  parameter int          GRID_W     = 205,
  parameter int          GRID_H     = 154,
  parameter int          BRAM_DEPTH = 31570,
  parameter logic [7:0]  W_REST     = 8'd64,
  parameter logic [7:0]  W_AXIS     = 8'd16,
  parameter logic [7:0]  W_DIAG     = 8'd4
) (
  input  logic                          pixel_clk_in,
  input  logic                          rst_in,
  input  logic                          init_start_in,
  input  logic                          paint_valid_in,
  output logic                          paint_ready_out,
  input  logic [7:0]                    paint_x_in,
  input  logic [7:0]                    paint_y_in,
  input  logic                          paint_erase_in,
  output logic                          we_out,
  output logic [$clog2(BRAM_DEPTH)-1:0] addr_out,
  output logic [8:0][7:0]               data_out,
  output logic                          busy_out,
  output logic                          init_done_out
);

  // state    | meaning
  // INIT_ARM | one-cycle prelude, clears sweep counters
  // INIT     | one write per cycle over the whole grid, raster order
  // IDLE     | waiting for paint request or init restart
  // PAINT    | nine brush slots, one per cycle, skipped slots write nothing

  localparam int AW = $clog2(BRAM_DEPTH);

  localparam logic [8:0][7:0]   BARRIER    = '1;
  localparam logic [8:0][7:0]   REST       = {{4{W_DIAG}}, {4{W_AXIS}}, W_REST};
  localparam logic [7:0]        X_LAST     = 8'(GRID_W - 1);
  localparam logic [7:0]        Y_LAST     = 8'(GRID_H - 1);
  localparam logic [AW-1:0]     ADDR_LAST  = AW'(BRAM_DEPTH - 1);
  localparam logic [AW-1:0]     ROW_STRIDE = AW'(GRID_W);
  localparam logic signed [9:0] TX_MAX     = 10'(GRID_W - 2);
  localparam logic signed [9:0] TY_MAX     = 10'(GRID_H - 2);

  typedef enum logic [1:0] {INIT_ARM, INIT, IDLE, PAINT} state_t;

  state_t state, next_state;

  logic [7:0]          x_cnt, y_cnt;
  logic [AW-1:0]       addr_cnt;
  logic [7:0]          px_q, py_q;
  logic                erase_q;
  logic signed [1:0]   dx_q, dy_q;
  logic [3:0]          slot_cnt;

  logic                accept;
  logic                init_border;
  logic signed [9:0]   tx, ty;
  logic                tgt_ok;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [8:0][7:0]     wr_data;

  assign paint_ready_out = (state == IDLE) & init_done_out & ~init_start_in;

  // State register
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) state <= INIT_ARM;
    else         state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      INIT_ARM: next_state = INIT;
      INIT:     if (addr_cnt == ADDR_LAST) next_state = IDLE;
      IDLE: begin
        if (init_start_in) begin
          next_state = INIT_ARM;
        end else if (paint_valid_in && paint_ready_out) begin
          accept     = 1'b1;
          next_state = PAINT;
        end
      end
      PAINT:    if (slot_cnt == 4'd8) next_state = IDLE;
      default:  next_state = INIT_ARM;
    endcase
  end

  // Brush target; 10-bit signed so x-1 at x=0 goes negative and x+1 at 255
  // does not wrap back into the grid.
  always_comb begin
    tx = $signed({2'b00, px_q}) + $signed({{8{dx_q[1]}}, dx_q});
    ty = $signed({2'b00, py_q}) + $signed({{8{dy_q[1]}}, dy_q});
    // Only interior cells are paintable; the border is fixed after init.
    tgt_ok = (tx >= 10'sd1) && (tx <= TX_MAX) && (ty >= 10'sd1) && (ty <= TY_MAX);
  end

  assign init_border = (x_cnt == 8'd0) || (x_cnt == X_LAST) ||
                       (y_cnt == 8'd0) || (y_cnt == Y_LAST);

  // Write request for the current state, registered onto the outputs below.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    case (state)
      INIT: begin
        wr_en   = 1'b1;
        wr_addr = addr_cnt;
        wr_data = init_border ? BARRIER : REST;
      end
      PAINT: begin
        wr_en   = tgt_ok;
        wr_addr = AW'($unsigned(ty)) * ROW_STRIDE + AW'($unsigned(tx));
        wr_data = erase_q ? REST : BARRIER;
      end
      default: ;
    endcase
  end

  // Counters, request latch and registered outputs
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      x_cnt         <= '0;
      y_cnt         <= '0;
      addr_cnt      <= '0;
      px_q          <= '0;
      py_q          <= '0;
      erase_q       <= 1'b0;
      dx_q          <= '0;
      dy_q          <= '0;
      slot_cnt      <= '0;
      we_out        <= 1'b0;
      addr_out      <= '0;
      data_out      <= '0;
      busy_out      <= 1'b0;
      init_done_out <= 1'b0;
    end else begin
      we_out   <= wr_en;
      addr_out <= wr_addr;
      data_out <= wr_data;
      busy_out <= (next_state != IDLE);

      if (next_state == INIT_ARM)
        init_done_out <= 1'b0;
      else if (state == INIT && next_state == IDLE)
        init_done_out <= 1'b1;

      case (state)
        INIT_ARM: begin
          x_cnt    <= '0;
          y_cnt    <= '0;
          addr_cnt <= '0;
        end
        INIT: begin
          addr_cnt <= addr_cnt + AW'(1);
          if (x_cnt == X_LAST) begin
            x_cnt <= '0;
            y_cnt <= y_cnt + 8'd1;
          end else begin
            x_cnt <= x_cnt + 8'd1;
          end
        end
        IDLE: begin
          if (accept) begin
            px_q     <= paint_x_in;
            py_q     <= paint_y_in;
            erase_q  <= paint_erase_in;
            dx_q     <= -2'sd1;
            dy_q     <= -2'sd1;
            slot_cnt <= '0;
          end
        end
        PAINT: begin
          slot_cnt <= slot_cnt + 4'd1;
          if (dx_q == 2'sd1) begin
            dx_q <= -2'sd1;
            dy_q <= dy_q + 2'sd1;
          end else begin
            dx_q <= dx_q + 2'sd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_writer.sv
// Directed self-checking bench for grid_writer: initial sweep, brush painting
// at interior/corner/edge/out-of-grid centres, erase, back-to-back requests,
// init priority over paint, and reset in the middle of a sweep.
module tb_grid_writer;

  localparam int DEPTH = 31570;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             init_start;
  logic             paint_valid;
  logic             paint_ready;
  logic [7:0]       paint_x;
  logic [7:0]       paint_y;
  logic             paint_erase;
  logic             we;
  logic [14:0]      addr;
  logic [8:0][7:0]  data;
  logic             busy;
  logic             init_done;

  int checks = 0;
  int errors = 0;

  logic [8:0][7:0] bar_pat;
  logic [8:0][7:0] rest_pat;

  grid_writer dut (
    .pixel_clk_in    (clk),
    .rst_in          (rst_n),
    .init_start_in   (init_start),
    .paint_valid_in  (paint_valid),
    .paint_ready_out (paint_ready),
    .paint_x_in      (paint_x),
    .paint_y_in      (paint_y),
    .paint_erase_in  (paint_erase),
    .we_out          (we),
    .addr_out        (addr),
    .data_out        (data),
    .busy_out        (busy),
    .init_done_out   (init_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full-sweep checker: expects DEPTH consecutive writes in raster order.
  task automatic run_init_check(input string tag);
    int n = 0, bad = 0, gaps = 0, cyc = 0, ex = 0, ey = 0;
    bit started = 0;
    logic [8:0][7:0] ed, d0, d204, d206;
    d0 = '0; d204 = '0; d206 = '0;
    while (n < DEPTH && cyc < DEPTH + 50) begin
      tick();
      cyc++;
      if (we === 1'b1) begin
        started = 1;
        ed = (ex == 0 || ex == 204 || ey == 0 || ey == 153) ? bar_pat : rest_pat;
        if (addr !== 15'(n) || data !== ed) bad++;
        if (n < DEPTH - 1 && init_done !== 1'b0) bad++;
        if (n == DEPTH - 1 && init_done !== 1'b1) bad++;
        if (n == 0) d0 = data;
        if (n == 204) d204 = data;
        if (n == 206) d206 = data;
        n++;
        if (ex == 204) begin ex = 0; ey++; end else ex++;
      end else if (started) begin
        gaps++;
      end
    end
    checks++;
    if (n !== DEPTH) begin errors++; $display("FAIL %s write_count: got %0d expected %0d", tag, n, DEPTH); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL %s write_content: got %0d bad writes expected 0", tag, bad); end
    checks++;
    if (gaps !== 0) begin errors++; $display("FAIL %s write_gaps: got %0d expected 0", tag, gaps); end
    checks++;
    if (d0 !== bar_pat) begin errors++; $display("FAIL %s addr0_data: got %h expected %h", tag, d0, bar_pat); end
    checks++;
    if (d204 !== bar_pat) begin errors++; $display("FAIL %s addr204_data: got %h expected %h", tag, d204, bar_pat); end
    checks++;
    if (d206 !== rest_pat) begin errors++; $display("FAIL %s addr206_data: got %h expected %h", tag, d206, rest_pat); end
    tick();
    checks++;
    if (we !== 1'b0 || busy !== 1'b0 || init_done !== 1'b1 || paint_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_after_init: got we=%b busy=%b done=%b ready=%b expected 0 0 1 1",
               tag, we, busy, init_done, paint_ready);
    end
  endtask

  // One brush operation; ea[s] is the expected address of slot s, -1 = skipped.
  task automatic do_paint(input string tag, input logic [7:0] px, input logic [7:0] py,
                          input logic er, input int ea [9], input bit poke_init);
    logic [8:0][7:0] ed;
    logic exp_we;
    ed = er ? rest_pat : bar_pat;
    checks++;
    if (paint_ready !== 1'b1) begin errors++; $display("FAIL %s ready_before: got %b expected 1", tag, paint_ready); end
    paint_valid = 1'b1; paint_x = px; paint_y = py; paint_erase = er;
    tick();
    paint_valid = 1'b0;
    for (int s = 0; s < 9; s++) begin
      checks++;
      if (paint_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s ready_busy_slot%0d: got ready=%b busy=%b expected 0 1", tag, s, paint_ready, busy);
      end
      if (poke_init && s == 3) init_start = 1'b1;
      tick();
      init_start = 1'b0;
      exp_we = (ea[s] >= 0);
      checks++;
      if (we !== exp_we || (exp_we && (addr !== 15'(ea[s]) || data !== ed))) begin
        errors++;
        $display("FAIL %s slot%0d: got we=%b addr=%0d data=%h expected we=%b addr=%0d data=%h",
                 tag, s, we, addr, data, exp_we, ea[s], ed);
      end
    end
    checks++;
    if (paint_ready !== 1'b1 || init_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_after: got ready=%b done=%b busy=%b expected 1 1 0", tag, paint_ready, init_done, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; init_start = 1'b0; paint_valid = 1'b0;
    paint_x = '0; paint_y = '0; paint_erase = 1'b0;
    repeat (3) tick();
    checks++;
    if (we !== 1'b0 || addr !== '0 || data !== '0) begin
      errors++; $display("FAIL reset_write_outs: got we=%b addr=%0d data=%h expected 0 0 0", we, addr, data);
    end
    checks++;
    if (busy !== 1'b0 || init_done !== 1'b0 || paint_ready !== 1'b0) begin
      errors++; $display("FAIL reset_status: got busy=%b done=%b ready=%b expected 0 0 0", busy, init_done, paint_ready);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (we !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL arm_cycle: got we=%b busy=%b expected 0 1", we, busy);
    end
  endtask

  task automatic test_init_sweep();
    run_init_check("init");
  endtask

  task automatic test_paint_barrier();
    int ea [9] = '{1854, 1855, 1856, 2059, 2060, 2061, 2264, 2265, 2266};
    do_paint("paint_10_10", 8'd10, 8'd10, 1'b0, ea, 1'b0);
  endtask

  task automatic test_paint_corner();
    int ea [9] = '{-1, -1, -1, -1, 206, 207, -1, 411, 412};
    do_paint("paint_1_1", 8'd1, 8'd1, 1'b0, ea, 1'b0);
  endtask

  task automatic test_paint_edges();
    int ea0 [9] = '{-1, -1, -1, -1, -1, -1, -1, -1, 206};
    int ea1 [9] = '{31157, 31158, -1, 31362, 31363, -1, -1, -1, -1};
    int ea2 [9] = '{-1, -1, -1, -1, -1, -1, -1, -1, -1};
    do_paint("paint_0_0", 8'd0, 8'd0, 1'b0, ea0, 1'b0);
    do_paint("paint_203_152", 8'd203, 8'd152, 1'b0, ea1, 1'b0);
    do_paint("paint_255_255", 8'd255, 8'd255, 1'b0, ea2, 1'b0);
  endtask

  // Erase also pokes init_start mid-paint, which must be ignored.
  task automatic test_paint_erase();
    int ea [9] = '{1854, 1855, 1856, 2059, 2060, 2061, 2264, 2265, 2266};
    do_paint("erase_10_10", 8'd10, 8'd10, 1'b1, ea, 1'b1);
    tick();
    checks++;
    if (we !== 1'b0 || busy !== 1'b0 || init_done !== 1'b1) begin
      errors++; $display("FAIL erase_init_ignored: got we=%b busy=%b done=%b expected 0 0 1", we, busy, init_done);
    end
  endtask

  task automatic test_back_to_back();
    int first = -1, last = -1, bad = 0, cyc = 0;
    paint_valid = 1'b1; paint_x = 8'd20; paint_y = 8'd20; paint_erase = 1'b0;
    tick();
    paint_x = 8'd30; paint_y = 8'd30;
    for (int s = 0; s < 9; s++) begin
      if (paint_ready !== 1'b0) bad++;
      tick();
      if (we === 1'b1) begin
        if (first < 0) first = int'(addr);
        last = int'(addr);
      end
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL b2b_ready_mid_paint: got %0d high cycles expected 0", bad); end
    checks++;
    if (first !== 3914 || last !== 4326) begin
      errors++; $display("FAIL b2b_first_op: got first=%0d last=%0d expected 3914 4326", first, last);
    end
    checks++;
    if (paint_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_return: got %b expected 1", paint_ready); end
    tick();
    paint_valid = 1'b0;
    checks++;
    if (paint_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_second_accept: got ready=%b busy=%b expected 0 1", paint_ready, busy);
    end
    tick();
    checks++;
    if (we !== 1'b1 || addr !== 15'd5974) begin
      errors++; $display("FAIL b2b_second_first_write: got we=%b addr=%0d expected 1 5974", we, addr);
    end
    while (paint_ready !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    checks++;
    if (paint_ready !== 1'b1) begin errors++; $display("FAIL b2b_finish: got ready=%b expected 1", paint_ready); end
  endtask

  // init_start beats a simultaneous paint; then reset lands mid-sweep.
  task automatic test_init_priority();
    int n = 0, bad = 0, cyc = 0;
    bit hit = 0;
    paint_valid = 1'b1; paint_x = 8'd50; paint_y = 8'd50; paint_erase = 1'b0;
    init_start = 1'b1;
    #1;
    checks++;
    if (paint_ready !== 1'b0) begin errors++; $display("FAIL prio_ready: got %b expected 0", paint_ready); end
    tick();
    init_start = 1'b0; paint_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || init_done !== 1'b0 || we !== 1'b0) begin
      errors++; $display("FAIL prio_arm: got busy=%b done=%b we=%b expected 1 0 0", busy, init_done, we);
    end
    while (!hit && cyc < 1100) begin
      tick();
      cyc++;
      if (we === 1'b1) begin
        if (addr !== 15'(n)) bad++;
        if (addr === 15'd1000) hit = 1;
        n++;
      end
    end
    checks++;
    if (bad !== 0 || n !== 1001) begin
      errors++; $display("FAIL reinit_prefix: got %0d writes %0d bad expected 1001 writes 0 bad", n, bad);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (we !== 1'b0 || addr !== '0 || data !== '0 || init_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midinit_reset: got we=%b addr=%0d data=%h done=%b busy=%b expected all 0",
               we, addr, data, init_done, busy);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    run_init_check("post_reset");
  endtask

  initial begin
    bar_pat  = '1;
    rest_pat = {8'd4, 8'd4, 8'd4, 8'd4, 8'd16, 8'd16, 8'd16, 8'd16, 8'd64};
    test_reset();
    test_init_sweep();
    test_paint_barrier();
    test_paint_corner();
    test_paint_edges();
    test_paint_erase();
    test_back_to_back();
    test_init_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
